// File: rtl/life_pkg.sv
// Shared definitions for the game-of-life control block: state encoding,
// state width and the default generation rate.
package life_pkg;

    localparam int STATE_W          = 3;
    localparam int DEFAULT_TICK_DIV = 1000000;

    typedef enum logic [STATE_W-1:0] {
        IDLE    = 3'd0,
        PROGRAM = 3'd1,
        RUN     = 3'd2,
        PAUSE   = 3'd3,
        STEP    = 3'd4,
        DONE    = 3'd5
    } game_state_t;

endpackage

// File: rtl/life_edge_det.sv
// Parametrised-width rising-edge detector. A bit of rise is high while the
// input is 1 and the previous registered sample was 0.
module life_edge_det
    import life_pkg::*;
#(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] din,
    output logic [W-1:0] rise
);

    logic [W-1:0] prev;

    // previous-sample register, cleared by reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) prev <= '0;
        else     prev <= din;
    end

    assign rise = din & ~prev;

endmodule

// File: rtl/life_game_ctrl.sv
// Game-of-life control FSM: sequences programming, free-running generations,
// pause/single-step and completion; drives the generation strobe, the
// generation counter and the cell-programming cursor. All outputs registered.
module life_game_ctrl
    import life_pkg::*;
#(
    parameter int CELLS    = 64,
    parameter int ADDR_W   = 6,
    parameter int TICK_DIV = DEFAULT_TICK_DIV,
    parameter int DIV_W    = 20,
    parameter int GEN_W    = 16,
    parameter int MAX_GEN  = 0
) (
    input  logic               clka,
    input  logic               rst,
    input  logic               stop,
    input  logic               prgm,
    input  logic               pp,
    input  logic               step,
    input  logic               btn0,
    input  logic               btn1,
    input  logic               board_empty,
    output logic [STATE_W-1:0] game_state,
    output logic               gen_tick,
    output logic [GEN_W-1:0]   gen_count,
    output logic [ADDR_W-1:0]  prog_addr,
    output logic               prog_toggle
);

    game_state_t       state, state_n;
    logic [DIV_W-1:0]  div, div_n;
    logic [GEN_W-1:0]  gen_count_n;
    logic [ADDR_W-1:0] prog_addr_n;
    logic              gen_tick_n, prog_toggle_n;
    logic              adv_pend, adv_pend_n;

    logic [4:0]        ev;
    logic              ev_pp, ev_prgm, ev_step, ev_btn0, ev_btn1;

    logic [ADDR_W-1:0] addr_inc;
    logic [GEN_W-1:0]  count_inc;
    logic              div_end, run_limit, step_limit;

    life_edge_det #(.W(5)) u_edge (
        .clk  (clka),
        .rst  (rst),
        .din  ({pp, prgm, step, btn0, btn1}),
        .rise (ev)
    );

    assign {ev_pp, ev_prgm, ev_step, ev_btn0, ev_btn1} = ev;

    assign addr_inc   = (prog_addr == ADDR_W'(CELLS - 1)) ? '0 : prog_addr + 1'b1;
    assign count_inc  = gen_count + 1'b1;
    assign div_end    = (div == DIV_W'(TICK_DIV - 1));
    assign run_limit  = (MAX_GEN != 0) && (count_inc == GEN_W'(MAX_GEN));
    assign step_limit = (MAX_GEN != 0) && (gen_count == GEN_W'(MAX_GEN));

    assign game_state = state;

    // state and output registers
    always_ff @(posedge clka or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            div         <= '0;
            gen_count   <= '0;
            prog_addr   <= '0;
            gen_tick    <= 1'b0;
            prog_toggle <= 1'b0;
            adv_pend    <= 1'b0;
        end else begin
            state       <= state_n;
            div         <= div_n;
            gen_count   <= gen_count_n;
            prog_addr   <= prog_addr_n;
            gen_tick    <= gen_tick_n;
            prog_toggle <= prog_toggle_n;
            adv_pend    <= adv_pend_n;
        end
    end

    // next-state and next-output decode
    always_comb begin
        state_n       = state;
        div_n         = div;
        gen_count_n   = gen_count;
        // a cursor advance deferred from a simultaneous btn0/btn1 lands now,
        // so the toggle strobe is seen with the old address
        prog_addr_n   = adv_pend ? addr_inc : prog_addr;
        gen_tick_n    = 1'b0;
        prog_toggle_n = 1'b0;
        adv_pend_n    = 1'b0;

        if (stop) begin
            state_n     = IDLE;
            div_n       = '0;
            gen_count_n = '0;
            prog_addr_n = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (ev_prgm) begin
                        state_n     = PROGRAM;
                        gen_count_n = '0;
                        prog_addr_n = '0;
                    end
                end
                PROGRAM: begin
                    if (ev_pp) begin
                        state_n = RUN;
                        div_n   = '0;
                    end else if (ev_btn1) begin
                        prog_toggle_n = 1'b1;
                        adv_pend_n    = ev_btn0;
                    end else if (ev_btn0) begin
                        prog_addr_n = addr_inc;
                    end
                end
                RUN: begin
                    if (ev_pp) begin
                        state_n = PAUSE;
                    end else if (div_end) begin
                        div_n = '0;
                        if (board_empty) begin
                            state_n = DONE;
                        end else begin
                            gen_tick_n  = 1'b1;
                            gen_count_n = count_inc;
                            if (run_limit) state_n = DONE;
                        end
                    end else begin
                        div_n = div + 1'b1;
                    end
                end
                PAUSE: begin
                    if (ev_pp) begin
                        state_n = RUN;
                        div_n   = '0;
                    end else if (ev_step) begin
                        state_n     = STEP;
                        gen_tick_n  = 1'b1;
                        gen_count_n = count_inc;
                    end else if (ev_prgm) begin
                        state_n     = PROGRAM;
                        gen_count_n = '0;
                    end
                end
                STEP: begin
                    state_n = step_limit ? DONE : PAUSE;
                end
                DONE: begin
                    if (ev_prgm) begin
                        state_n     = PROGRAM;
                        gen_count_n = '0;
                    end
                end
                default: begin
                    state_n = IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_life_game_ctrl.sv
// Self-checking bench for life_game_ctrl: two instances (unlimited and
// MAX_GEN=2) share stimulus; a directed vector table, hand sequences for
// the limit and async-reset cases, and a randomized run against a model.
module tb_life_game_ctrl;

    localparam int T_DIV   = 4;
    localparam int N_CELLS = 8;
    localparam int CNT_MOD = 16;

    localparam logic [4:0] N0 = 5'b00000;
    localparam logic [4:0] PP = 5'b10000;
    localparam logic [4:0] PG = 5'b01000;
    localparam logic [4:0] ST = 5'b00100;
    localparam logic [4:0] B0 = 5'b00010;
    localparam logic [4:0] B1 = 5'b00001;

    logic       clka = 1'b0;
    logic       rst  = 1'b1;
    logic       stop = 1'b0, prgm = 1'b0, pp = 1'b0, step = 1'b0;
    logic       btn0 = 1'b0, btn1 = 1'b0, board_empty = 1'b0;

    logic [2:0] gs0, gs2;
    logic       tk0, tk2, tg0, tg2;
    logic [3:0] gc0, gc2;
    logic [2:0] pa0, pa2;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clka = ~clka;

    life_game_ctrl #(.CELLS(8), .ADDR_W(3), .TICK_DIV(4), .DIV_W(2), .GEN_W(4), .MAX_GEN(0)) dut (
        .clka(clka), .rst(rst), .stop(stop), .prgm(prgm), .pp(pp), .step(step),
        .btn0(btn0), .btn1(btn1), .board_empty(board_empty),
        .game_state(gs0), .gen_tick(tk0), .gen_count(gc0), .prog_addr(pa0), .prog_toggle(tg0)
    );

    life_game_ctrl #(.CELLS(8), .ADDR_W(3), .TICK_DIV(4), .DIV_W(2), .GEN_W(4), .MAX_GEN(2)) dut_lim (
        .clka(clka), .rst(rst), .stop(stop), .prgm(prgm), .pp(pp), .step(step),
        .btn0(btn0), .btn1(btn1), .board_empty(board_empty),
        .game_state(gs2), .gen_tick(tk2), .gen_count(gc2), .prog_addr(pa2), .prog_toggle(tg2)
    );

    // ---------------- reference model ----------------
    typedef struct {
        int       st;
        int       dv;
        int       cnt;
        int       addr;
        bit       adv;
        bit       tick;
        bit       tog;
        bit [4:0] prev;
    } mdl_t;

    mdl_t m0, m2;

    function automatic mdl_t mstep(mdl_t m, bit [4:0] lv, bit stp, bit emp, int lim);
        mdl_t r = m;
        bit [4:0] e = lv & ~m.prev;
        r.prev = lv;
        r.tick = 0;
        r.tog  = 0;
        r.adv  = 0;
        if (m.adv) r.addr = (m.addr + 1) % N_CELLS;
        if (stp) begin
            r.st = 0; r.cnt = 0; r.addr = 0; r.dv = 0;
            return r;
        end
        case (m.st)
            0: if (e[3]) begin r.st = 1; r.cnt = 0; r.addr = 0; end
            1: begin
                if (e[4]) begin r.st = 2; r.dv = 0; end
                else if (e[0]) begin r.tog = 1; r.adv = e[1]; end
                else if (e[1]) r.addr = (m.addr + 1) % N_CELLS;
            end
            2: begin
                if (e[4]) r.st = 3;
                else if (m.dv == T_DIV - 1) begin
                    r.dv = 0;
                    if (emp) r.st = 5;
                    else begin
                        r.tick = 1;
                        r.cnt  = (m.cnt + 1) % CNT_MOD;
                        if (lim != 0 && r.cnt == lim) r.st = 5;
                    end
                end else r.dv = m.dv + 1;
            end
            3: begin
                if (e[4]) begin r.st = 2; r.dv = 0; end
                else if (e[2]) begin r.st = 4; r.tick = 1; r.cnt = (m.cnt + 1) % CNT_MOD; end
                else if (e[3]) begin r.st = 1; r.cnt = 0; end
            end
            4: r.st = (lim != 0 && m.cnt == lim) ? 5 : 3;
            5: if (e[3]) begin r.st = 1; r.cnt = 0; end
            default: r.st = 0;
        endcase
        return r;
    endfunction

    function automatic logic [11:0] mpack(mdl_t m);
        return {3'(m.st), m.tick, 4'(m.cnt), 3'(m.addr), m.tog};
    endfunction

    function automatic logic [11:0] exp(int st, int tk, int cnt, int ad, int tg);
        return {3'(st), 1'(tk), 4'(cnt), 3'(ad), 1'(tg)};
    endfunction

    // ---------------- helpers ----------------
    task automatic chk(input string name, input logic [11:0] act, input logic [11:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got st=%0d tick=%0b cnt=%0d addr=%0d tog=%0b, expected st=%0d tick=%0b cnt=%0d addr=%0d tog=%0b",
                     name, act[11:9], act[8], act[7:4], act[3:1], act[0],
                     req[11:9], req[8], req[7:4], req[3:1], req[0]);
        end
    endtask

    task automatic reset_models();
        m0 = '{default: 0};
        m2 = '{default: 0};
    endtask

    task automatic cyc(input logic [4:0] lv, input logic s, input logic e);
        {pp, prgm, step, btn0, btn1} = lv;
        stop        = s;
        board_empty = e;
        @(posedge clka);
        m0 = mstep(m0, lv, s, e, 0);
        m2 = mstep(m2, lv, s, e, 2);
        #1;
        chk("model_unlim", {gs0, tk0, gc0, pa0, tg0}, mpack(m0));
        chk("model_lim2",  {gs2, tk2, gc2, pa2, tg2}, mpack(m2));
    endtask

    task automatic do_reset();
        {pp, prgm, step, btn0, btn1} = N0;
        stop = 0; board_empty = 0;
        rst = 1;
        repeat (2) @(posedge clka);
        #1;
        chk("reset_unlim", {gs0, tk0, gc0, pa0, tg0}, 12'h000);
        chk("reset_lim2",  {gs2, tk2, gc2, pa2, tg2}, 12'h000);
        rst = 0;
        reset_models();
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic [4:0]  lv;
        logic        stp;
        logic        emp;
        logic [11:0] want;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic [4:0] lv, input logic stp, input logic emp,
                       input int st, input int tk, input int cnt, input int ad, input int tg);
        vec_t v;
        v.lv = lv; v.stp = stp; v.emp = emp; v.want = exp(st, tk, cnt, ad, tg);
        tbl.push_back(v);
    endtask

    initial begin
        logic [4:0] rl;

        // cursor walk with wrap at CELLS
        add(PG, 0, 0, 1, 0, 0, 0, 0);
        add(N0, 0, 0, 1, 0, 0, 0, 0);
        for (int i = 1; i <= 9; i++) begin
            add(B0, 0, 0, 1, 0, 0, i % N_CELLS, 0);
            add(N0, 0, 0, 1, 0, 0, i % N_CELLS, 0);
        end
        // move cursor to 5, simultaneous btn0+btn1, then run
        for (int i = 2; i <= 5; i++) begin
            add(B0, 0, 0, 1, 0, 0, i, 0);
            add(N0, 0, 0, 1, 0, 0, i, 0);
        end
        add(B0 | B1, 0, 0, 1, 0, 0, 5, 1);
        add(N0, 0, 0, 1, 0, 0, 6, 0);
        add(PP, 0, 0, 2, 0, 0, 6, 0);
        for (int k = 1; k <= 12; k++)
            add(N0, 0, 0, 2, (k % 4 == 0) ? 1 : 0, k / 4, 6, 0);
        // pause on the terminal-count edge, then single step
        for (int k = 0; k < 3; k++) add(N0, 0, 0, 2, 0, 3, 6, 0);
        add(PP, 0, 0, 3, 0, 3, 6, 0);
        add(N0, 0, 0, 3, 0, 3, 6, 0);
        add(ST, 0, 0, 4, 1, 4, 6, 0);
        add(N0, 0, 0, 3, 0, 4, 6, 0);
        // empty board at terminal count, then DONE handling
        add(PP, 0, 0, 2, 0, 4, 6, 0);
        for (int k = 0; k < 3; k++) add(N0, 0, 0, 2, 0, 4, 6, 0);
        add(N0, 0, 1, 5, 0, 4, 6, 0);
        add(PP, 0, 0, 5, 0, 4, 6, 0);
        add(N0, 0, 0, 5, 0, 4, 6, 0);
        add(ST, 0, 0, 5, 0, 4, 6, 0);
        add(N0, 0, 0, 5, 0, 4, 6, 0);
        add(PG, 0, 0, 1, 0, 0, 6, 0);
        add(N0, 0, 0, 1, 0, 0, 6, 0);
        // stop while in STEP
        add(PP, 0, 0, 2, 0, 0, 6, 0);
        add(N0, 0, 0, 2, 0, 0, 6, 0);
        add(PP, 0, 0, 3, 0, 0, 6, 0);
        add(N0, 0, 0, 3, 0, 0, 6, 0);
        add(ST, 0, 0, 4, 1, 1, 6, 0);
        add(N0, 1, 0, 0, 0, 0, 0, 0);
        add(N0, 0, 0, 0, 0, 0, 0, 0);

        reset_models();
        #2;
        do_reset();
        foreach (tbl[i]) begin
            cyc(tbl[i].lv, tbl[i].stp, tbl[i].emp);
            chk($sformatf("vec%0d", i), {gs0, tk0, gc0, pa0, tg0}, tbl[i].want);
        end

        // generation limit reached in RUN
        do_reset();
        cyc(PG, 0, 0);
        cyc(N0, 0, 0);
        cyc(PP, 0, 0);
        for (int k = 1; k <= 8; k++) begin
            cyc(N0, 0, 0);
            if (k == 4) chk("lim_tick1", {gs2, tk2, gc2, pa2, tg2}, exp(2, 1, 1, 0, 0));
            if (k == 8) begin
                chk("lim_done", {gs2, tk2, gc2, pa2, tg2}, exp(5, 1, 2, 0, 0));
                chk("unlim_tick2", {gs0, tk0, gc0, pa0, tg0}, exp(2, 1, 2, 0, 0));
            end
        end
        cyc(PP, 0, 0);
        chk("lim_done_pp", {gs2, tk2, gc2, pa2, tg2}, exp(5, 0, 2, 0, 0));
        chk("unlim_pause", {gs0, tk0, gc0, pa0, tg0}, exp(3, 0, 2, 0, 0));
        cyc(N0, 0, 0);
        cyc(PG, 0, 0);
        chk("lim_done_prgm", {gs2, tk2, gc2, pa2, tg2}, exp(1, 0, 0, 0, 0));
        chk("unlim_pause_prgm", {gs0, tk0, gc0, pa0, tg0}, exp(1, 0, 0, 0, 0));

        // asynchronous reset between edges, just before a terminal count
        do_reset();
        cyc(PG, 0, 0);
        cyc(N0, 0, 0);
        cyc(B0, 0, 0);
        cyc(N0, 0, 0);
        cyc(PP, 0, 0);
        for (int k = 1; k <= 7; k++) cyc(N0, 0, 0);
        chk("pre_async", {gs0, tk0, gc0, pa0, tg0}, exp(2, 0, 1, 1, 0));
        #3 rst = 1;
        #1;
        chk("async_now_unlim", {gs0, tk0, gc0, pa0, tg0}, 12'h000);
        chk("async_now_lim2",  {gs2, tk2, gc2, pa2, tg2}, 12'h000);
        @(posedge clka);
        #1;
        chk("async_no_strobe", {gs0, tk0, gc0, pa0, tg0}, 12'h000);
        rst = 0;
        reset_models();

        // randomized run against the model
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            for (int b = 0; b < 5; b++) rl[b] = ($urandom_range(0, 2) == 0);
            cyc(rl, ($urandom_range(0, 59) == 0), ($urandom_range(0, 7) == 0));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
